// File: rtl/cva6_ras_ckpt_pkg.sv
// Shared types and default sizing for the return-address stack with checkpoints.
package cva6_ras_ckpt_pkg;

  localparam int unsigned RAS_DEPTH  = 2;
  localparam int unsigned RAS_VLEN   = 64;
  localparam int unsigned RAS_CKPT_N = 4;

  typedef struct packed {
    logic                valid;
    logic [RAS_VLEN-1:0] ra;
  } ras_t;

  typedef struct packed {
    logic [$clog2(RAS_DEPTH)-1:0]   tos;
    logic [$clog2(RAS_DEPTH+1)-1:0] cnt;
    logic [RAS_VLEN-1:0]            top;
  } ras_ckpt_t;

endpackage

// File: rtl/cva6_ras_ckpt_if.sv
// Frontend-facing port bundle of the RAS: stack ops, top readout and checkpoint control.
// There is no stall handshake: every request is taken in the cycle it is presented.
interface cva6_ras_ckpt_if #(
  parameter int unsigned VLEN   = 64,
  parameter int unsigned CKPT_N = 4
);
  localparam int unsigned IW = (CKPT_N > 1) ? $clog2(CKPT_N) : 1;

  logic            flush_i;
  logic            push_i;
  logic            pop_i;
  logic [VLEN-1:0] data_i;
  logic [VLEN:0]   data_o;
  logic            ckpt_alloc_i;
  logic [IW-1:0]   ckpt_id_o;
  logic            ckpt_full_o;
  logic            restore_i;
  logic [IW-1:0]   restore_id_i;
  logic            release_i;
  logic [IW-1:0]   release_id_i;

  modport master (
    output flush_i, push_i, pop_i, data_i, ckpt_alloc_i,
           restore_i, restore_id_i, release_i, release_id_i,
    input  data_o, ckpt_id_o, ckpt_full_o
  );

  modport slave (
    input  flush_i, push_i, pop_i, data_i, ckpt_alloc_i,
           restore_i, restore_id_i, release_i, release_id_i,
    output data_o, ckpt_id_o, ckpt_full_o
  );
endinterface

// File: rtl/cva6_ras_ckpt_lzc.sv
// Lowest-set-bit finder: cnt is the index of the lowest set bit of in, empty when none is set.
module cva6_ras_ckpt_lzc #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in,
  output logic [IW-1:0]    cnt,
  output logic             empty
);

  // Scan downwards so the lowest set bit is the last one to win.
  always_comb begin
    cnt   = '0;
    empty = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in[i]) begin
        cnt   = IW'(i);
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cva6_ras_ckpt.sv
// Return-address stack with one-cycle mispredict repair from checkpoints.
// Checkpoint slots exist only when RAS_CKPT_EN is defined; otherwise it is a plain RAS.
module cva6_ras_ckpt
  import cva6_ras_ckpt_pkg::*;
#(
  parameter int unsigned DEPTH  = RAS_DEPTH,
  parameter int unsigned VLEN   = RAS_VLEN,
  parameter int unsigned CKPT_N = RAS_CKPT_N
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  cva6_ras_ckpt_if.slave  ras
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (CKPT_N > 1) ? $clog2(CKPT_N) : 1;

  logic [VLEN-1:0]   entry_q [DEPTH];
  logic [PW-1:0]     tos_q, tos_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_en;
  logic [VLEN-1:0]   wr_data;
  logic [CKPT_N-1:0] busy_q;
  logic              restore_hit;
  logic [PW-1:0]     rs_tos;
  logic [CW-1:0]     rs_cnt;
  logic [VLEN-1:0]   rs_top;
  logic [IW-1:0]     free_id;
  logic              none_free;

  assign ras.data_o      = {cnt_q != '0, entry_q[tos_q]};
  assign ras.ckpt_id_o   = free_id;
  assign ras.ckpt_full_o = none_free;

  // Every write lands on the next top-of-stack, so the write index is tos_d.
  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_data = ras.data_i;
    if (ras.flush_i) begin
      tos_d = '0;
      cnt_d = '0;
    end else if (restore_hit) begin
      tos_d   = rs_tos;
      cnt_d   = rs_cnt;
      wr_en   = 1'b1;
      wr_data = rs_top;
    end else if (ras.push_i && ras.pop_i) begin
      wr_en = 1'b1;
      if (cnt_q == '0) cnt_d = CW'(1);
    end else if (ras.push_i) begin
      tos_d = tos_q + PW'(1);
      wr_en = 1'b1;
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (ras.pop_i && cnt_q != '0) begin
      tos_d = tos_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tos_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (wr_en) entry_q[tos_d] <= wr_data;
    end
  end

`ifdef RAS_CKPT_EN
  typedef struct packed {
    logic [PW-1:0]   tos;
    logic [CW-1:0]   cnt;
    logic [VLEN-1:0] top;
  } slot_t;

  slot_t             slot_q [CKPT_N];
  logic [CKPT_N-1:0] busy_d;
  logic              alloc_take;
  logic [VLEN-1:0]   top_d;

  assign restore_hit = ras.restore_i && busy_q[ras.restore_id_i];
  assign rs_tos      = slot_q[ras.restore_id_i].tos;
  assign rs_cnt      = slot_q[ras.restore_id_i].cnt;
  assign rs_top      = slot_q[ras.restore_id_i].top;
  assign alloc_take  = ras.ckpt_alloc_i && !none_free && !ras.flush_i;
  assign top_d       = wr_en ? wr_data : entry_q[tos_d];

  // free_id comes from the pre-update busy vector, so a slot freed this cycle is not reused yet.
  always_comb begin
    busy_d = busy_q;
    if (ras.flush_i) begin
      busy_d = '0;
    end else begin
      if (restore_hit)   busy_d[ras.restore_id_i] = 1'b0;
      if (ras.release_i) busy_d[ras.release_id_i] = 1'b0;
      if (alloc_take)    busy_d[free_id]          = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
      for (int i = 0; i < CKPT_N; i++) slot_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (alloc_take) slot_q[free_id] <= '{tos: tos_d, cnt: cnt_d, top: top_d};
    end
  end
`else
  logic ckpt_unused;

  // All slots permanently busy: the finder then reports full with id 0.
  assign busy_q      = '1;
  assign restore_hit = 1'b0;
  assign rs_tos      = '0;
  assign rs_cnt      = '0;
  assign rs_top      = '0;
  assign ckpt_unused = ^{ras.ckpt_alloc_i, ras.restore_i, ras.restore_id_i,
                         ras.release_i, ras.release_id_i};
`endif

  cva6_ras_ckpt_lzc #(.WIDTH(CKPT_N)) i_lzc (
    .in    (~busy_q),
    .cnt   (free_id),
    .empty (none_free)
  );

endmodule

// File: tb/tb_cva6_ras_ckpt.sv
// Self-checking bench for cva6_ras_ckpt against a behavioural stack/checkpoint model.
// Build with +define+RAS_CKPT_EN to exercise the checkpoint slots.
module tb_cva6_ras_ckpt;
  import cva6_ras_ckpt_pkg::*;

  localparam int DEPTH  = 2;
  localparam int VLEN   = 64;
  localparam int CKPT_N = 4;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  cva6_ras_ckpt_if #(.VLEN(VLEN), .CKPT_N(CKPT_N)) bus ();

  cva6_ras_ckpt #(.DEPTH(DEPTH), .VLEN(VLEN), .CKPT_N(CKPT_N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ras    (bus)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  int              m_tos, m_cnt;
  logic [VLEN-1:0] m_ent [DEPTH];
  bit              m_busy [CKPT_N];
  int              mk_tos [CKPT_N];
  int              mk_cnt [CKPT_N];
  logic [VLEN-1:0] mk_top [CKPT_N];

  function automatic logic [VLEN:0] m_data();
    ras_t r;
    r.valid = (m_cnt != 0);
    r.ra    = m_ent[m_tos];
    return r;
  endfunction

  function automatic int m_free_id();
`ifdef RAS_CKPT_EN
    for (int i = 0; i < CKPT_N; i++) if (!m_busy[i]) return i;
`endif
    return 0;
  endfunction

  function automatic bit m_full();
`ifdef RAS_CKPT_EN
    for (int i = 0; i < CKPT_N; i++) if (!m_busy[i]) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic model_step(input bit rst, flush, push, pop, input logic [VLEN-1:0] d,
                            input bit alloc, restore, input int rid, input bit rel, input int relid);
    int fid;
    bit full;
    bit hit;
    if (rst) begin
      m_tos = 0;
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
      for (int i = 0; i < CKPT_N; i++) m_busy[i] = 1'b0;
      return;
    end
    fid  = m_free_id();
    full = m_full();
    hit  = 1'b0;
    if (flush) begin
      m_tos = 0;
      m_cnt = 0;
      for (int i = 0; i < CKPT_N; i++) m_busy[i] = 1'b0;
      return;
    end
`ifdef RAS_CKPT_EN
    hit = restore && m_busy[rid];
`endif
    if (hit) begin
      m_tos = mk_tos[rid];
      m_cnt = mk_cnt[rid];
      m_ent[m_tos] = mk_top[rid];
      m_busy[rid] = 1'b0;
    end else if (push && pop) begin
      m_ent[m_tos] = d;
      if (m_cnt == 0) m_cnt = 1;
    end else if (push) begin
      m_tos = (m_tos + 1) % DEPTH;
      m_ent[m_tos] = d;
      m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
    end else if (pop && m_cnt > 0) begin
      m_tos = (m_tos + DEPTH - 1) % DEPTH;
      m_cnt = m_cnt - 1;
    end
`ifdef RAS_CKPT_EN
    if (rel) m_busy[relid] = 1'b0;
    if (alloc && !full) begin
      m_busy[fid] = 1'b1;
      mk_tos[fid] = m_tos;
      mk_cnt[fid] = m_cnt;
      mk_top[fid] = m_ent[m_tos];
    end
`endif
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic drive(input bit rst, flush, push, pop, input logic [VLEN-1:0] d,
                       input bit alloc, restore, input int rid, input bit rel, input int relid);
    rst_n            = !rst;
    bus.flush_i      = flush;
    bus.push_i       = push;
    bus.pop_i        = pop;
    bus.data_i       = d;
    bus.ckpt_alloc_i = alloc;
    bus.restore_i    = restore;
    bus.restore_id_i = 2'(rid);
    bus.release_i    = rel;
    bus.release_id_i = 2'(relid);
    model_step(rst, flush, push, pop, d, alloc, restore, rid, rel, relid);
    @(posedge clk);
    @(negedge clk);
    rst_n            = 1'b1;
    bus.flush_i      = 1'b0;
    bus.push_i       = 1'b0;
    bus.pop_i        = 1'b0;
    bus.ckpt_alloc_i = 1'b0;
    bus.restore_i    = 1'b0;
    bus.release_i    = 1'b0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush_all();
    drive(0, 1, 0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1, 0, 1, 0, 64'hdead_beef_0000_1234, 1, 0, 0, 0, 0);
    n_vec++;
    if (bus.data_o !== {1'b0, 64'h0}) begin
      n_err++; $display("FAIL reset_data: got %h expected %h", bus.data_o, {1'b0, 64'h0});
    end
    n_vec++;
    if (bus.ckpt_id_o !== 2'd0 || bus.ckpt_full_o !== m_full()) begin
      n_err++; $display("FAIL reset_ckpt: got id %0d full %0b expected id 0 full %0b",
                        bus.ckpt_id_o, bus.ckpt_full_o, m_full());
    end
    drive(0, 0, 0, 1, '0, 0, 0, 0, 0, 0);
    n_vec++;
    if (bus.data_o !== {1'b0, 64'h0}) begin
      n_err++; $display("FAIL pop_empty: got %h expected %h", bus.data_o, {1'b0, 64'h0});
    end
  endtask

  task automatic test_overflow();
    logic [VLEN-1:0] vals [3];
    vals[0] = 64'h8000_0010; vals[1] = 64'h8000_0020; vals[2] = 64'h8000_0030;
    flush_all();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, vals[i], 0, 0, 0, 0, 0);
      n_vec++;
      if (bus.data_o !== {1'b1, vals[i]}) begin
        n_err++; $display("FAIL overflow_push%0d: got %h expected %h", i, bus.data_o, {1'b1, vals[i]});
      end
    end
    drive(0, 0, 0, 1, '0, 0, 0, 0, 0, 0);
    n_vec++;
    if (bus.data_o !== {1'b1, vals[1]}) begin
      n_err++; $display("FAIL overflow_pop1: got %h expected %h", bus.data_o, {1'b1, vals[1]});
    end
    for (int i = 2; i <= 3; i++) begin
      drive(0, 0, 0, 1, '0, 0, 0, 0, 0, 0);
      n_vec++;
      if (bus.data_o[VLEN] !== 1'b0 || bus.data_o !== m_data()) begin
        n_err++; $display("FAIL overflow_pop%0d: got %h expected %h", i, bus.data_o, m_data());
      end
    end
  endtask

  task automatic test_push_pop();
    flush_all();
    drive(0, 0, 1, 0, 64'h8000_0010, 0, 0, 0, 0, 0);
    bus.push_i = 1'b1; bus.pop_i = 1'b1; bus.data_i = 64'h8000_0040;
    #1;
    n_vec++;
    if (bus.data_o !== {1'b1, 64'h8000_0010}) begin
      n_err++; $display("FAIL pushpop_same_cycle: got %h expected %h", bus.data_o, {1'b1, 64'h8000_0010});
    end
    drive(0, 0, 1, 1, 64'h8000_0040, 0, 0, 0, 0, 0);
    n_vec++;
    if (bus.data_o !== {1'b1, 64'h8000_0040}) begin
      n_err++; $display("FAIL pushpop_next: got %h expected %h", bus.data_o, {1'b1, 64'h8000_0040});
    end
    drive(0, 0, 0, 1, '0, 0, 0, 0, 0, 0);
    n_vec++;
    if (bus.data_o[VLEN] !== 1'b0) begin
      n_err++; $display("FAIL pushpop_cnt1: got valid %0b expected 0", bus.data_o[VLEN]);
    end
  endtask

  task automatic test_restore();
    flush_all();
    drive(0, 0, 1, 0, 64'h8000_0010, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, '0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 64'h8000_0020, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 64'h8000_0030, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, '0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 64'h8000_0050, 0, 1, 0, 0, 0);
    n_vec++;
    if (bus.data_o !== m_data() || bus.ckpt_id_o !== 2'(m_free_id())) begin
      n_err++; $display("FAIL restore: got %h id %0d expected %h id %0d",
                        bus.data_o, bus.ckpt_id_o, m_data(), m_free_id());
    end
`ifdef RAS_CKPT_EN
    n_vec++;
    if (bus.data_o !== {1'b1, 64'h8000_0010} || bus.ckpt_id_o !== 2'd0) begin
      n_err++; $display("FAIL restore_literal: got %h id %0d expected %h id 0",
                        bus.data_o, bus.ckpt_id_o, {1'b1, 64'h8000_0010});
    end
`endif
  endtask

  task automatic test_alloc_full();
    flush_all();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (bus.ckpt_id_o !== 2'(m_free_id()) || bus.ckpt_full_o !== m_full()) begin
        n_err++; $display("FAIL alloc%0d: got id %0d full %0b expected id %0d full %0b",
                          i, bus.ckpt_id_o, bus.ckpt_full_o, m_free_id(), m_full());
      end
      drive(0, 0, 0, 0, '0, 1, 0, 0, 0, 0);
    end
    n_vec++;
    if (bus.ckpt_full_o !== m_full()) begin
      n_err++; $display("FAIL alloc_full: got %0b expected %0b", bus.ckpt_full_o, m_full());
    end
    drive(0, 0, 0, 0, '0, 0, 0, 0, 1, 2);
    n_vec++;
    if (bus.ckpt_id_o !== 2'(m_free_id()) || bus.ckpt_full_o !== m_full()) begin
      n_err++; $display("FAIL release2: got id %0d full %0b expected id %0d full %0b",
                        bus.ckpt_id_o, bus.ckpt_full_o, m_free_id(), m_full());
    end
    drive(0, 0, 0, 0, '0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, '0, 0, 0, 0, 1, 3);
    drive(0, 0, 0, 0, '0, 1, 0, 0, 1, 2);
    n_vec++;
    if (bus.ckpt_id_o !== 2'(m_free_id()) || bus.ckpt_full_o !== m_full()) begin
      n_err++; $display("FAIL release_alloc_same: got id %0d full %0b expected id %0d full %0b",
                        bus.ckpt_id_o, bus.ckpt_full_o, m_free_id(), m_full());
    end
  endtask

  task automatic test_flush();
    flush_all();
    drive(0, 0, 1, 0, 64'h8000_0110, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 64'h8000_0120, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, '0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, '0, 1, 1, 0, 0, 0);
    n_vec++;
    if (bus.data_o[VLEN] !== 1'b0 || bus.data_o !== m_data()) begin
      n_err++; $display("FAIL flush_data: got %h expected %h", bus.data_o, m_data());
    end
    n_vec++;
    if (bus.ckpt_id_o !== 2'd0 || bus.ckpt_full_o !== m_full()) begin
      n_err++; $display("FAIL flush_ckpt: got id %0d full %0b expected id 0 full %0b",
                        bus.ckpt_id_o, bus.ckpt_full_o, m_full());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit rst, flush, push, pop, alloc, restore, rel;
      rst     = ($urandom_range(0, 63) == 0);
      flush   = ($urandom_range(0, 15) == 0);
      push    = $urandom_range(0, 1);
      pop     = $urandom_range(0, 1);
      alloc   = ($urandom_range(0, 2) == 0);
      restore = ($urandom_range(0, 4) == 0);
      rel     = ($urandom_range(0, 3) == 0);
      drive(rst, flush, push, pop, {$urandom, $urandom}, alloc, restore,
            $urandom_range(0, CKPT_N - 1), rel, $urandom_range(0, CKPT_N - 1));
      n_vec++;
      if ({bus.data_o, bus.ckpt_id_o, bus.ckpt_full_o} !== {m_data(), 2'(m_free_id()), m_full()}) begin
        n_err++; $display("FAIL random%0d: got %h/%0d/%0b expected %h/%0d/%0b", n,
                          bus.data_o, bus.ckpt_id_o, bus.ckpt_full_o, m_data(), m_free_id(), m_full());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.flush_i = 1'b0; bus.push_i = 1'b0; bus.pop_i = 1'b0; bus.data_i = '0;
    bus.ckpt_alloc_i = 1'b0; bus.restore_i = 1'b0; bus.restore_id_i = '0;
    bus.release_i = 1'b0; bus.release_id_i = '0;
    @(negedge clk);
    test_reset();
    test_overflow();
    test_push_pop();
    test_restore();
    test_alloc_full();
    test_flush();
    test_random();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cva6_ras_ckpt.md
# cva6_ras_ckpt

Return-address stack with misprediction checkpoints for the CVA6 frontend. It sits beside the branch predictor and is sized by the core configuration: DEPTH follows CVA6ConfigRASDepth (2 in the 64-bit IMAFDC Sv39 build), and VLEN follows the virtual-address width. Calls push return addresses and returns pop predicted targets. Each in-flight branch can snapshot the stack top, so a flush caused by a mispredict repairs the stack in one cycle.

## Interface
- DEPTH, 2, number of RAS entries; power of two, ≥2
- VLEN, 64, width of a return address
- CKPT_N, 4, number of simultaneously held checkpoints; power of two
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
- flush_i  in  1  empty the stack and free every checkpoint
- push_i  in  1  push data_i (call)
- pop_i  in  1  pop top (return)
- data_i  in  VLEN  return address to push
- data_o  out  1+VLEN  ras_t {valid, ra}: current top, combinational from state
- ckpt_alloc_i  in  1  take a checkpoint this cycle
- ckpt_id_o  out  $clog2(CKPT_N)  id the next allocation receives (lowest free)
- ckpt_full_o  out  1  no free checkpoint
- restore_i  in  1  restore checkpoint restore_id_i
- restore_id_i  in  $clog2(CKPT_N)  id to restore
- release_i  in  1  free checkpoint release_id_i (branch resolved correctly)
- release_id_i  in  $clog2(CKPT_N)  id to free

## Operation
- State: DEPTH entries, tos pointer ($clog2(DEPTH) bits, wraps mod DEPTH), cnt (0..DEPTH, $clog2(DEPTH+1) bits), and CKPT_N slots of ras_ckpt_t {tos, cnt, top} plus a busy bit per slot.
- data_o = {cnt!=0, entry[tos]}. It reflects pre-update state in every cycle.
- Priority: flush_i > restore_i > push/pop. Checkpoint alloc and release are evaluated independently of that order.
- Push only: tos+1, entry[tos+1]=data_i, cnt=min(cnt+1,DEPTH). On overflow the oldest entry is silently overwritten.
- Pop only: if cnt>0 then tos-1 and cnt-1. If cnt==0, no state change and data_o.valid=0.
- Push+pop same cycle: entry[tos]=data_i, tos unchanged, cnt=max(cnt,1).
- Restore (valid busy id): tos=ckpt.tos, cnt=ckpt.cnt, entry[ckpt.tos]=ckpt.top, and the slot is freed. Push/pop that cycle is dropped. A restore to a non-busy id is ignored, and push/pop then proceed normally. Entries other than the top are not repaired.
- Alloc: if !ckpt_full_o, slot ckpt_id_o captures the next-state {tos, cnt, top}, including this cycle's push/pop or restore, and becomes busy. An alloc while full is ignored.
- Release: clears the busy bit. Releasing a non-busy id is a no-op. A slot released or restored this cycle is not allocatable until the next cycle.
- Flush: tos=0, cnt=0, all busy bits clear. Alloc and restore are ignored that cycle. Entry contents are kept.

## Timing
- Reset: entries=0, tos=0, cnt=0, all slots free. Outputs are therefore data_o={0,0}, ckpt_id_o=0, ckpt_full_o=0.
- Reset mid-operation overrides every input in the same edge.
- data_o, ckpt_id_o and ckpt_full_o are combinational from registers with zero input-to-output paths.
- All updates take effect on the next rising edge, with one-cycle visibility.
- No handshake stalls. The caller must check ckpt_full_o before relying on an allocation.

## Configuration
- RAS_CKPT_EN defined: the checkpoint slots, alloc, restore and release behave as above.
- RAS_CKPT_EN undefined: all checkpoint storage is compiled out and ckpt_full_o is tied 1. ckpt_id_o is tied 0, and ckpt_alloc_i, restore_i and release_i are ignored. The stack behaves as a plain RAS that only flush_i resets.

## Structure
- ras_t {valid, ra} is shared in ariane_pkg.
- ras_ckpt_t and the CKPT_N default belong in the same package.
- One sub-module instance: common_cells lzc over the inverted busy vector, producing ckpt_id_o and ckpt_full_o (its empty_o).

## Test plan
- Reset, then pop_i=1 → data_o.valid=0, cnt stays 0, ckpt_id_o=0, ckpt_full_o=0.
- DEPTH=2: push 0x8000_0010, 0x8000_0020, 0x8000_0030, then pop ×3 → data_o.ra reads 0x…30 then 0x…20, then valid=0. Overflow keeps cnt at 2.
- Top=0x8000_0010 (cnt=1); push+pop with 0x8000_0040 → data_o shows 0x…10 that cycle, then 0x…40 next cycle, with cnt=1.
- Push 0x8000_0010, alloc (id 0), push 0x…20, push 0x…30, pop, restore id 0 with push_i=1 → next cycle data_o={1,0x8000_0010}, push dropped, id 0 free.
- Four allocs → ids 0,1,2,3 and ckpt_full_o=1. Fifth alloc is ignored. Release 2 → next cycle ckpt_full_o=0 and ckpt_id_o=2. Release+alloc of the same id in one cycle does not reuse it.
- With 2 busy slots and cnt=2, flush_i plus restore_i plus alloc in the same cycle → next cycle data_o.valid=0, all slots free, ckpt_id_o=0.
